// File: rtl/gyro_sample_sched.sv
// Gyro sampling controller: fixed-period tick, X/Y/Z reads over a req/ack handshake,
// zero-rate bias calibration and saturated bias-corrected rate outputs with a VALID strobe.
module gyro_sample_sched #(
  parameter int TICK_CYCLES = 50000,
  parameter int CAL_SAMPLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cal_i,
  output logic        rd_req_o,
  output logic [1:0]  rd_addr_o,
  input  logic        rd_ack_i,
  input  logic [15:0] rd_data_i,
  output logic [15:0] dx_o,
  output logic [15:0] dy_o,
  output logic [15:0] dz_o,
  output logic        valid_o,
  output logic        cal_busy_o,
  output logic        overrun_o
);
  localparam int CW = $clog2(TICK_CYCLES);
  localparam int SH = $clog2(CAL_SAMPLES);
  localparam int AW = 16 + SH;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [SH-1:0] SET_LAST  = SH'(CAL_SAMPLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RDX, S_RDY, S_RDZ, S_UPD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                tick, upd, consume, cap;
  logic [1:0]          cap_idx;
  logic                rd_req_q, rd_req_d;
  logic [1:0]          rd_addr_q, rd_addr_d;
  logic [2:0][15:0]    raw_q, bias_q, d_q, bias_new, d_sat;
  logic [2:0][16:0]    diff;
  logic [2:0][AW-1:0]  acc_q, acc_sum;
  logic [SH-1:0]       set_q;
  logic                pend_q, cal_busy_q, valid_q, overrun_q;

  assign tick    = (cnt_q == TICK_LAST);
  assign upd     = (state_q == S_UPD);
  // A pending or same-cycle CAL is taken only between sets, so an in-flight set finishes first.
  assign consume = (state_q == S_IDLE) && (pend_q || cal_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick)     state_d = S_RDX;
      S_RDX:   if (rd_ack_i) state_d = S_RDY;
      S_RDY:   if (rd_ack_i) state_d = S_RDZ;
      S_RDZ:   if (rd_ack_i) state_d = S_UPD;
      S_UPD:                 state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_req_d  = (state_d == S_RDX) || (state_d == S_RDY) || (state_d == S_RDZ);
    rd_addr_d = 2'd0;
    if (state_d == S_RDY) rd_addr_d = 2'd1;
    if (state_d == S_RDZ) rd_addr_d = 2'd2;
    cap       = 1'b0;
    cap_idx   = 2'd0;
    case (state_q)
      S_RDX: begin cap = rd_ack_i; cap_idx = 2'd0; end
      S_RDY: begin cap = rd_ack_i; cap_idx = 2'd1; end
      S_RDZ: begin cap = rd_ack_i; cap_idx = 2'd2; end
      default: ;
    endcase
  end

  // Accumulator is 16+SH wide, so its top 16 bits are exactly acc >>> SH.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      acc_sum[i]  = acc_q[i] + {{SH{raw_q[i][15]}}, raw_q[i]};
      bias_new[i] = acc_sum[i][AW-1:SH];
      diff[i]     = {raw_q[i][15], raw_q[i]} - {bias_q[i][15], bias_q[i]};
      if (diff[i][16] != diff[i][15])
        d_sat[i] = diff[i][16] ? 16'h8000 : 16'h7fff;
      else
        d_sat[i] = diff[i][15:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 2'd0;
      raw_q      <= '0;
      bias_q     <= '0;
      acc_q      <= '0;
      set_q      <= '0;
      d_q        <= '0;
      pend_q     <= 1'b0;
      cal_busy_q <= 1'b1;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cnt_q     <= tick ? '0 : cnt_q + 1'b1;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      pend_q    <= consume ? 1'b0 : (pend_q | cal_i);
      if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
      if (cap) raw_q[cap_idx] <= rd_data_i;
      valid_q <= upd && !cal_busy_q;
      if (upd && !cal_busy_q) d_q <= d_sat;
      if (consume) begin
        cal_busy_q <= 1'b1;
        acc_q      <= '0;
        set_q      <= '0;
        bias_q     <= '0;
      end else if (upd && cal_busy_q) begin
        if (set_q == SET_LAST) begin
          bias_q     <= bias_new;
          acc_q      <= '0;
          set_q      <= '0;
          cal_busy_q <= 1'b0;
        end else begin
          acc_q <= acc_sum;
          set_q <= set_q + 1'b1;
        end
      end
    end
  end

  assign rd_req_o   = rd_req_q;
  assign rd_addr_o  = rd_addr_q;
  assign dx_o       = d_q[0];
  assign dy_o       = d_q[1];
  assign dz_o       = d_q[2];
  assign valid_o    = valid_q;
  assign cal_busy_o = cal_busy_q;
  assign overrun_o  = overrun_q;
endmodule

// File: doc/gyro_sample_sched.md
# gyro_sample_sched

Sampling controller for the gyro rate/tilt datapath. It generates the fixed sample period and, each period, sequences three axis reads (X, Y, Z) from the gyro serial reader over a req/ack handshake. It removes a per-axis zero-rate bias measured during a calibration phase and presents one coherent, bias-corrected rate triple per period with a VALID strobe. Its outputs drive the tilt integrator directly: DX/DY/DZ go to the integrator's rate inputs, and VALID replaces the integrator's free-running sample counter.

## Interface
- TICK_CYCLES, 50000 — sample period in CLK cycles (1 ms at 50 MHz); minimum 8.
- CAL_SAMPLES, 16 — number of sample sets averaged for bias; power of two, 2..256.

- CLK  in  1  — system clock; all logic on rising edge.
- RST  in  1  — reset, asynchronous, active-high.
- CAL  in  1  — recalibration request; single-cycle pulse.
- RD_REQ  out  1  — read request to gyro reader; held high until acknowledged.
- RD_ADDR  out  2  — axis for the current request: 0=X, 1=Y, 2=Z. Value 3 is never driven.
- RD_ACK  in  1  — single-cycle pulse; RD_DATA is valid in the same cycle.
- RD_DATA  in  16  — raw signed angular rate, two's complement.
- DX, DY, DZ  out  16  — signed, bias-corrected rate outputs.
- VALID  out  1  — single-cycle pulse; DX/DY/DZ updated in that cycle.
- CAL_BUSY  out  1  — high while calibration is in progress.
- OVERRUN  out  1  — sticky; a tick arrived while a sample set was still in progress.

## Operation
- **Tick counter:** counts 0..TICK_CYCLES-1 and wraps. It asserts an internal tick when the count equals TICK_CYCLES-1, so the first tick occurs TICK_CYCLES cycles after reset release. The counter runs continuously, including during calibration and during reads.
- **States:** IDLE, RD_X, RD_Y, RD_Z, UPDATE.
- **IDLE -> RD_X** on tick.
- **RD_n:** RD_REQ=1 with RD_ADDR=n. On a cycle with RD_ACK=1, RD_DATA is captured into the axis n raw register and the FSM advances: RD_X->RD_Y->RD_Z->UPDATE.
- **UPDATE -> IDLE** after one cycle.
- RD_ACK is ignored in IDLE and in UPDATE.
- **Tick while not in IDLE:** the tick is dropped and OVERRUN is set. OVERRUN clears only on RST.
- **Calibration mode** (CAL_BUSY=1):
  - In UPDATE, each raw value is added to a per-axis signed accumulator of width 16+log2(CAL_SAMPLES), and the set count increments.
  - After the CAL_SAMPLES-th set, bias_n = acc_n >>> log2(CAL_SAMPLES) (arithmetic shift, truncating toward -inf).
  - In the same cycle, CAL_BUSY falls and the accumulators and set count clear.
  - VALID is not asserted, and DX/DY/DZ hold their values.
- **Run mode** (CAL_BUSY=0): in UPDATE, Dn = sat16(raw_n − bias_n), and VALID=1 for that cycle.
- **Saturation:** the subtraction is computed at 17 bits and clamped to the range [−32768, 32767].
- **CAL pulse:**
  - Sets a pending flag in any state.
  - If the FSM is in IDLE, the flag is consumed immediately. Otherwise it is consumed when the FSM returns to IDLE, so the in-flight set completes in run mode first.
  - Consumption clears the accumulators, set count and bias, and sets CAL_BUSY=1.
  - A CAL pulse during calibration restarts calibration from zero.
- **After RST:** the block enters calibration automatically.

## Timing
- **Reset values:** RD_REQ=0, RD_ADDR=0, DX=DY=DZ=0, VALID=0, CAL_BUSY=1, OVERRUN=0. Tick counter, biases, accumulators, set count and pending CAL flag are all 0. FSM is in IDLE.
- **Registered outputs:** all outputs are registered. RD_REQ rises the cycle after the tick cycle.
- **RD_ACK handling:**
  - An RD_ACK sampled in RD_X changes RD_ADDR to 1 in the next cycle, with RD_REQ held at 1.
  - RD_REQ never drops between axes.
  - RD_REQ falls the cycle after the RD_ACK sampled in RD_Z.
- **Zero-wait reader (ack in the first request cycle):**
  - tick at cycle t
  - RD_X at t+1, RD_Y at t+2, RD_Z at t+3
  - UPDATE at t+4, with VALID high at t+5 (registered)
- **Latency:** DX/DY/DZ change in the same cycle that VALID is high.
- **Reader stalls:** no timeout. RD_REQ stays high indefinitely, and later ticks only set OVERRUN.
- **RST mid-read:** RD_REQ drops asynchronously. Partial sets are discarded and calibration restarts.
- **CAL and tick in the same cycle while in IDLE:** CAL takes priority in that cycle. The FSM still moves to RD_X, and that set counts as calibration set 1.

## Test plan
Bench parameters: TICK_CYCLES=10, CAL_SAMPLES=4.

1. **Reset and auto-calibration:**
   - Stimulus: RST, then a zero-wait reader returning X=100, Y=−20, Z=3 for 4 sets, then X=150, Y=−20, Z=0.
   - Required: CAL_BUSY falls after set 4 with no VALID during calibration. The fifth set gives DX=50, DY=0, DZ=−3, and VALID is exactly 1 cycle wide.
2. **Handshake timing:**
   - Stimulus: reader acks each request 3 cycles after RD_REQ rises.
   - Required: RD_ADDR sequences 0,1,2 with RD_REQ continuously high. VALID appears 1 cycle after the UPDATE state, per the cycle numbering above. An ack injected in IDLE is ignored.
3. **Overrun:**
   - Stimulus: reader withholds the X ack for 15 cycles.
   - Required: OVERRUN=1 after the next tick, and stays 1 after the set completes. Exactly one VALID for that set.
4. **Saturation:**
   - Stimulus: bias X=−100, then raw X=32700.
   - Required: DX=32767.
   - Stimulus: bias Z=100, then raw Z=−32760.
   - Required: DZ=−32768.
5. **CAL mid-set:**
   - Stimulus: CAL pulse while in RD_Y.
   - Required: the current set completes in run mode with VALID=1. CAL_BUSY rises the following cycle in IDLE. The bias is recomputed from the next 4 sets.
6. **RST mid-read:**
   - Stimulus: assert RST while RD_REQ=1 in RD_Z.
   - Required: RD_REQ and all outputs go to their reset values without waiting for a CLK edge. CAL_BUSY=1 and OVERRUN=0.
